// File: rtl/pix_fetch_pkg.sv
// Shared types and helpers for the pix_fetch framebuffer scanout engine.
package pix_fetch_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DRAIN
  } state_e;

  // Out-of-range bank selects collapse onto the last implemented bank.
  function automatic int unsigned clamp_sel(input int unsigned sel, input int unsigned num_images);
    return (sel >= num_images) ? num_images - 1 : sel;
  endfunction

endpackage

// File: rtl/pix_fetch_fifo.sv
// Synchronous FIFO with registered occupancy count and a flush that empties it in one cycle.
module sync_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic             empty_o,
  output logic [CW-1:0]    count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push, do_pop;

  assign do_pop  = pop_i && (count_q != '0);
  assign do_push = push_i && ((count_q != CW'(DEPTH)) || do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  // NOTE: the storage array has no reset; pointers and count alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= data_i;
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

endmodule

// File: rtl/pix_fetch.sv
// Framebuffer scanout: bank-selectable address generator feeding a prefetch FIFO toward the pixel consumer.
module pix_fetch
  import pix_fetch_pkg::*;
#(
  parameter  int ADDR_W     = 32,
  parameter  int PIX_W      = 8,
  parameter  int H_ACTIVE   = 256,
  parameter  int V_ACTIVE   = 256,
  parameter  int NUM_IMAGES = 2,
  parameter  int IMG_STRIDE = 65536,
  parameter  int FIFO_DEPTH = 16,
  localparam int SEL_W      = (NUM_IMAGES > 1) ? $clog2(NUM_IMAGES) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [SEL_W-1:0]  img_sel,
  input  logic              frame_start,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [PIX_W-1:0]  mem_data,
  input  logic              pix_ready,
  output logic              pix_valid,
  output logic [PIX_W-1:0]  pix_data,
  output logic              underrun,
  output logic              frame_done
);

  localparam int TOTAL  = H_ACTIVE * V_ACTIVE;
  localparam int FCNT_W = $clog2(TOTAL + 1);
  localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   base_q, base_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [FCNT_W-1:0]   fetch_cnt_q, fetch_cnt_d;
  logic [FCNT_W-1:0]   pop_cnt_q, pop_cnt_d;
  logic                rd_issue_q, rd_issue_d;   // address on the bus this cycle
  logic                rd_pend_q, rd_pend_d;     // data on the bus this cycle
  logic                underrun_q, underrun_d;
  logic                flush, pop, fifo_empty;
  logic [CNT_W-1:0]    fifo_count;
  logic [CNT_W:0]      occupancy;
  logic [PIX_W-1:0]    fifo_head;

  assign pop       = pix_ready && pix_valid;
  assign occupancy = {1'b0, fifo_count} + (CNT_W + 1)'(rd_issue_q) + (CNT_W + 1)'(rd_pend_q);

  // NOTE: every combinational output gets a default first, so no path leaves a variable unassigned (no latches).
  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    mem_addr_d  = mem_addr_q;
    fetch_cnt_d = fetch_cnt_q;
    pop_cnt_d   = pop_cnt_q;
    rd_issue_d  = 1'b0;
    rd_pend_d   = rd_issue_q && !frame_start;
    underrun_d  = underrun_q;
    flush       = 1'b0;
    frame_done  = 1'b0;

    if (frame_start) begin
      // The first read of the new frame is issued right away so its address is on the bus next cycle.
      base_d      = ADDR_W'(clamp_sel(32'(img_sel), NUM_IMAGES)) * ADDR_W'(IMG_STRIDE);
      mem_addr_d  = base_d;
      rd_issue_d  = 1'b1;
      fetch_cnt_d = FCNT_W'(1);
      pop_cnt_d   = '0;
      underrun_d  = 1'b0;
      flush       = 1'b1;
      state_d     = (TOTAL == 1) ? DRAIN : FETCH;
    end else begin
      if (state_q == FETCH &&
          occupancy < (CNT_W + 1)'(FIFO_DEPTH) + (CNT_W + 1)'(pop)) begin
        rd_issue_d  = 1'b1;
        mem_addr_d  = base_q + ADDR_W'(fetch_cnt_q);
        fetch_cnt_d = fetch_cnt_q + 1'b1;
        if (fetch_cnt_q == FCNT_W'(TOTAL - 1)) state_d = DRAIN;
      end
      if (pop) begin
        pop_cnt_d = pop_cnt_q + 1'b1;
        if (pop_cnt_q == FCNT_W'(TOTAL - 1)) begin
          frame_done = 1'b1;
          state_d    = IDLE;
        end
      end
      if (state_q != IDLE && pix_ready && !pix_valid) underrun_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      base_q      <= '0;
      mem_addr_q  <= '0;
      fetch_cnt_q <= '0;
      pop_cnt_q   <= '0;
      rd_issue_q  <= 1'b0;
      rd_pend_q   <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      mem_addr_q  <= mem_addr_d;
      fetch_cnt_q <= fetch_cnt_d;
      pop_cnt_q   <= pop_cnt_d;
      rd_issue_q  <= rd_issue_d;
      rd_pend_q   <= rd_pend_d;
      underrun_q  <= underrun_d;
    end
  end

  sync_fifo #(
    .WIDTH (PIX_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (reset),
    .flush_i (flush),
    .push_i  (rd_pend_q),
    .data_i  (mem_data),
    .pop_i   (pop),
    .data_o  (fifo_head),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign pix_valid = !fifo_empty;
  assign pix_data  = pix_valid ? fifo_head : '0;
  assign mem_addr  = mem_addr_q;
  assign underrun  = underrun_q;

endmodule
